// File: rtl/freq_ratio_detector.sv
// freq_ratio_detector: measures period and high time of a clk-synchronous divided clock,
// reports the recovered ratio, lock on a stable ratio, ratio changes and missing edges.
module freq_ratio_detector #(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    input  logic             clr,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_vld,
    output logic             locked,
    output logic             err,
    output logic             timeout
);
    localparam logic [CNT_W-1:0] SAT    = '1;
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] LOCK_N = CNT_W'(LOCK_CNT);
    typedef enum logic [1:0] {IDLE, MEAS, LOCK} state_t;
    state_t           state_q;
    logic             div_in_q, rise, tmo, mis;
    logic             vld_q, locked_q, err_q, timeout_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d, match_q, match_d, period_q, high_q;
    always_comb begin
        rise    = div_in & ~div_in_q;
        cnt_d   = rise ? ONE : (cnt_q == SAT ? SAT : cnt_q + ONE);
        hcnt_d  = rise ? ONE : ((div_in && hcnt_q != SAT) ? hcnt_q + ONE : hcnt_q);
        match_d = (cnt_q == period_q && match_q != '0) ? match_q + ONE : ONE;
        tmo     = !rise && cnt_d == SAT;
        mis     = rise && state_q == LOCK && cnt_q != period_q;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            div_in_q  <= 1'b0;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            match_q   <= '0;
            period_q  <= '0;
            high_q    <= '0;
            vld_q     <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            div_in_q <= div_in;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            vld_q    <= 1'b0;
            // a mismatch in the same cycle as clr keeps err set
            err_q    <= mis | (err_q & ~clr);
            if (tmo) begin
                timeout_q <= 1'b1;
                locked_q  <= 1'b0;
                match_q   <= '0;
                state_q   <= IDLE;
            end else if (rise) begin
                if (state_q == IDLE) begin
                    state_q   <= MEAS;
                    match_q   <= '0;
                    timeout_q <= 1'b0;
                end else begin
                    period_q <= cnt_q;
                    high_q   <= hcnt_q;
                    vld_q    <= 1'b1;
                    if (state_q == MEAS) begin
                        match_q <= match_d;
                        if (match_d >= LOCK_N) begin
                            state_q  <= LOCK;
                            locked_q <= 1'b1;
                        end
                    end else if (mis) begin
                        match_q  <= ONE;
                        locked_q <= 1'b0;
                        state_q  <= MEAS;
                    end
                end
            end
        end
    end
    assign period     = period_q;
    assign high_time  = high_q;
    assign period_vld = vld_q;
    assign locked     = locked_q;
    assign err        = err_q;
    assign timeout    = timeout_q;
endmodule

// File: tb/tb_freq_ratio_detector.sv
// tb_freq_ratio_detector: table vectors, hand corner sequences and random periods checked
// every cycle against a timestamp-based model of the detector.
module tb_freq_ratio_detector;
    localparam int CNT_W    = 8;
    localparam int LOCK_CNT = 2;
    localparam int SAT      = 255;

    logic clk = 1'b0, rst = 1'b0, div_in = 1'b0, clr = 1'b0;
    logic [CNT_W-1:0] period, high_time;
    logic period_vld, locked, err, timeout;
    int checks = 0, failures = 0;

    freq_ratio_detector #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
        .clk(clk), .rst(rst), .div_in(div_in), .clr(clr),
        .period(period), .high_time(high_time), .period_vld(period_vld),
        .locked(locked), .err(err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // model: ratio derived from rise timestamps and the recorded input waveform
    int  t = 0, anchor = 0, streak = 0;
    bit  prevd = 0, armed = 0;
    bit  m_locked = 0, m_err = 0, m_tmo = 0, m_vld = 0;
    int  m_period = 0, m_high = 0;
    bit  hist[32768];

    task automatic model_step(input bit r, input bit d, input bit c);
        bit rise, mis;
        int p, h;
        hist[t] = d;
        if (!r) begin
            prevd = 0; armed = 0; streak = 0;
            m_locked = 0; m_err = 0; m_tmo = 0; m_vld = 0;
            m_period = 0; m_high = 0;
            anchor = t + 1;
        end else begin
            rise = d && !prevd;
            mis = 0;
            m_vld = 0;
            if (rise) begin
                if (armed) begin
                    p = (t - anchor > SAT) ? SAT : t - anchor;
                    h = 0;
                    for (int i = anchor; i < t; i++) h += int'(hist[i]);
                    if (h > SAT) h = SAT;
                    if (m_locked) begin
                        if (p != m_period) begin
                            mis = 1; m_locked = 0; streak = 1;
                        end
                    end else begin
                        streak = (p == m_period && streak > 0) ? streak + 1 : 1;
                        if (streak >= LOCK_CNT) m_locked = 1;
                    end
                    m_period = p; m_high = h; m_vld = 1;
                end else begin
                    armed = 1; streak = 0; m_tmo = 0;
                end
                anchor = t;
            end else if (t + 1 - anchor >= SAT) begin
                m_tmo = 1; m_locked = 0; armed = 0; streak = 0;
            end
            if (mis) m_err = 1;
            else if (c) m_err = 0;
            prevd = d;
        end
        t++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit d, input bit c);
        rst = r; div_in = d; clr = c;
        @(posedge clk);
        model_step(r, d, c);
        #1;
        chk("mdl_period", 32'(period), 32'(m_period));
        chk("mdl_high", 32'(high_time), 32'(m_high));
        chk("mdl_vld", 32'(period_vld), 32'(m_vld));
        chk("mdl_locked", 32'(locked), 32'(m_locked));
        chk("mdl_err", 32'(err), 32'(m_err));
        chk("mdl_timeout", 32'(timeout), 32'(m_tmo));
    endtask

    task automatic run(input int hi, input int lo, input int n);
        for (int k = 0; k < n; k++) begin
            repeat (hi) step(1, 1, 0);
            repeat (lo) step(1, 0, 0);
        end
    endtask

    typedef struct {
        int hi; int lo; int n;
        int e_period; int e_high; bit e_locked; bit e_err;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int hi, lo, r;
        bit c;
        vecs[0] = '{2, 2, 3, 4, 2, 1'b1, 1'b0};
        vecs[1] = '{3, 3, 1, 4, 2, 1'b1, 1'b0};
        vecs[2] = '{3, 3, 1, 6, 3, 1'b0, 1'b1};
        vecs[3] = '{3, 3, 1, 6, 3, 1'b1, 1'b1};
        vecs[4] = '{1, 1, 3, 2, 1, 1'b1, 1'b1};
        vecs[5] = '{1, 3, 3, 4, 1, 1'b1, 1'b1};

        step(0, 0, 0);
        step(0, 0, 0);
        chk("reset_outputs", {period, high_time, 4'(0), period_vld, locked, err, timeout}, 0);

        foreach (vecs[i]) begin
            run(vecs[i].hi, vecs[i].lo, vecs[i].n);
            chk($sformatf("vec%0d_period", i), 32'(period), vecs[i].e_period);
            chk($sformatf("vec%0d_high", i), 32'(high_time), vecs[i].e_high);
            chk($sformatf("vec%0d_locked", i), 32'(locked), 32'(vecs[i].e_locked));
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].e_err));
        end

        step(1, 0, 1);
        chk("clr_alone", 32'(err), 0);
        step(1, 1, 1);
        chk("clr_vs_mismatch_err", 32'(err), 1);
        chk("mismatch_period", 32'(period), 5);
        chk("mismatch_vld", 32'(period_vld), 1);
        chk("mismatch_unlock", 32'(locked), 0);
        step(1, 0, 1);
        chk("clr_next_cycle", 32'(err), 0);

        repeat (252) step(1, 0, 0);
        chk("timeout_early", 32'(timeout), 0);
        step(1, 0, 0);
        chk("timeout_set", 32'(timeout), 1);
        chk("timeout_locked", 32'(locked), 0);
        step(1, 1, 0);
        chk("timeout_cleared", 32'(timeout), 0);
        chk("timeout_rise_vld", 32'(period_vld), 0);
        chk("timeout_period_hold", 32'(period), 5);

        run(1, 1, 4);
        chk("div2_locked", 32'(locked), 1);
        step(0, 1, 0);
        chk("midreset_outputs", {period, high_time, 4'(0), period_vld, locked, err, timeout}, 0);
        step(1, 1, 0);
        chk("post_reset_first_edge_vld", 32'(period_vld), 0);
        step(1, 0, 0);
        step(1, 1, 0);
        chk("post_reset_vld", 32'(period_vld), 1);
        chk("post_reset_period", 32'(period), 2);
        chk("post_reset_high", 32'(high_time), 1);

        hi = 2; lo = 2;
        for (int s = 0; s < 200; s++) begin
            r = int'($urandom_range(0, 99));
            if (r < 20) begin
                hi = int'($urandom_range(1, 8));
                lo = int'($urandom_range(1, 8));
            end
            if (r == 99) step(0, 1, 0);
            else if (r >= 95) repeat ($urandom_range(250, 270)) step(1, 0, $urandom_range(0, 31) == 0);
            else if (r >= 93) repeat ($urandom_range(250, 270)) step(1, 1, 0);
            c = ($urandom_range(0, 15) == 0);
            repeat (hi) step(1, 1, c);
            repeat (lo) step(1, 0, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
